// File: rtl/stream_edge_pkg.sv
// ============================================================================
//  Module   : stream_edge_pkg
//  Purpose  : Shared constants and state encoding for the stream-edge encoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_edge_pkg;

    localparam logic [7:0] c_TAG_DATA = 8'h01;
    localparam logic [7:0] c_TAG_END  = 8'h00;
    localparam int         c_REC_LEN  = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TAG  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_TERM = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_edge_encoder.sv
// ============================================================================
//  Module   : stream_edge_encoder
//  Purpose  : Pops 16-bit kernel words and serialises them as TAG/HI/LO byte
//             records; emits a single terminator byte after finish, then halts.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_edge_encoder
    import stream_edge_pkg::*;
#(
    parameter logic [7:0] TAG_DATA    = c_TAG_DATA,
    parameter logic [7:0] TAG_END     = c_TAG_END,
    parameter int         COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            dout,
    input  logic                   avail,
    output logic                   read,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    input  logic                   finish,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] word_count
);

    localparam logic [COUNT_WIDTH-1:0] c_CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_next;
    logic [15:0]             r_hold;
    logic                    r_finish_seen;
    logic [COUNT_WIDTH-1:0]  r_word_count;
    logic                    w_read;
    logic                    w_valid;
    logic                    w_done;
    logic [7:0]              w_byte;

    // A new word may be popped only when the previous record is complete
    assign w_read = !rst && avail &&
                    ((r_state == S_IDLE) || ((r_state == S_LO) && byte_ready));

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        w_done  = 1'b0;
        w_byte  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (avail)              w_next = S_TAG;
                else if (r_finish_seen) w_next = S_TERM;
            end
            S_TAG: begin
                w_valid = 1'b1;
                w_byte  = TAG_DATA;
                if (byte_ready) w_next = S_HI;
            end
            S_HI: begin
                w_valid = 1'b1;
                w_byte  = r_hold[15:8];
                if (byte_ready) w_next = S_LO;
            end
            S_LO: begin
                w_valid = 1'b1;
                w_byte  = r_hold[7:0];
                // Pending data always wins over the terminator
                if (byte_ready) begin
                    if (avail)              w_next = S_TAG;
                    else if (r_finish_seen) w_next = S_TERM;
                    else                    w_next = S_IDLE;
                end
            end
            S_TERM: begin
                w_valid = 1'b1;
                w_byte  = TAG_END;
                if (byte_ready) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_hold        <= 16'h0000;
            r_finish_seen <= 1'b0;
            r_word_count  <= '0;
        end else begin
            r_state <= w_next;
            if (finish) r_finish_seen <= 1'b1;
            if (w_read) r_hold <= dout;
            if ((r_state == S_LO) && byte_ready) r_word_count <= r_word_count + c_CNT_ONE;
        end
    end

    assign read       = w_read;
    assign byte_valid = w_valid && !rst;
    assign byte_out   = rst ? 8'h00 : w_byte;
    assign done       = w_done && !rst;
    assign word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_stream_edge_encoder.sv
// ============================================================================
//  Module   : tb_stream_edge_encoder
//  Purpose  : Self-checking bench; expected byte stream is built from the list
//             of words offered to the encoder, plus the terminator on finish.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_edge_encoder;

    logic        clk;
    logic        rst;
    logic [15:0] dout;
    logic        avail;
    logic        read;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        finish;
    logic        done;
    logic [31:0] word_count;

    stream_edge_encoder #(
        .TAG_DATA    (8'h01),
        .TAG_END     (8'h00),
        .COUNT_WIDTH (32)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .dout       (dout),
        .avail      (avail),
        .read       (read),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .finish     (finish),
        .done       (done),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] src_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_count  = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_byte  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        src_q.push_back(w);
        exp_q.push_back('{b: 8'h01,    last: 1'b0});
        exp_q.push_back('{b: w[15:8],  last: 1'b0});
        exp_q.push_back('{b: w[7:0],   last: 1'b1});
    endtask

    // One clock: drive inputs after the falling edge, observe 1 time unit later
    task automatic tick(input bit rs, input bit rdy, input bit fin);
        exp_t e;
        @(negedge clk);
        rst        = rs;
        avail      = (src_q.size() != 0);
        dout       = avail ? src_q[0] : 16'($urandom);
        byte_ready = rdy;
        finish     = fin;
        #1;
        if (!rs && prev_stall) begin
            chk("hold_valid", {31'd0, byte_valid}, 32'd1);
            chk("hold_byte", {24'd0, byte_out}, {24'd0, prev_byte});
        end
        if (read) begin
            if (!avail) chk("read_without_avail", 32'd1, 32'd0);
            else        void'(src_q.pop_front());
        end
        if (!rs && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("byte", {24'd0, byte_out}, {24'd0, e.b});
                if (e.last) m_count++;
            end
        end
        prev_stall = !rs && byte_valid && !byte_ready;
        prev_byte  = byte_out;
        if (rs) m_count = 0;
    endtask

    task automatic drain(input int maxc, input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] burst_b[9];
        int         pushed;
        int         budget;

        rst = 1'b1; avail = 1'b0; dout = 16'h0; byte_ready = 1'b0; finish = 1'b0;
        burst_b = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h12, 8'h34, 8'h01, 8'hFF, 8'hFF};

        // Reset held with a word on offer
        src_q.push_back(16'hDEAD);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            chk("rst_read", {31'd0, read}, 32'd0);
            chk("rst_valid", {31'd0, byte_valid}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_count", word_count, 32'd0);
        end
        src_q.delete();

        // Single word latency
        push_word(16'hBEEF);
        tick(1'b0, 1'b1, 1'b0);
        chk("single_read", {31'd0, read}, 32'd1);
        chk("single_idle_valid", {31'd0, byte_valid}, 32'd0);
        tick(1'b0, 1'b1, 1'b0);
        chk("single_tag", {23'd0, byte_valid, byte_out}, 32'h101);
        tick(1'b0, 1'b1, 1'b0);
        chk("single_hi", {23'd0, byte_valid, byte_out}, 32'h1BE);
        tick(1'b0, 1'b1, 1'b0);
        chk("single_lo", {23'd0, byte_valid, byte_out}, 32'h1EF);
        tick(1'b0, 1'b1, 1'b0);
        chk("single_back_idle", {31'd0, byte_valid}, 32'd0);
        chk("single_count", word_count, 32'd1);

        // Back-to-back burst, no bubble
        push_word(16'h0001);
        push_word(16'h1234);
        push_word(16'hFFFF);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            chk($sformatf("burst_read_%0d", k), {31'd0, read},
                {31'd0, (k == 0 || k == 3 || k == 6)});
            if (k >= 1)
                chk($sformatf("burst_byte_%0d", k), {23'd0, byte_valid, byte_out},
                    {23'd1, burst_b[k-1]});
        end
        tick(1'b0, 1'b1, 1'b0);
        chk("burst_idle", {31'd0, byte_valid}, 32'd0);
        chk("burst_count", word_count, 32'd4);

        // Random words with random sink stalls
        pushed = 0;
        budget = 0;
        while ((pushed < 1000 || exp_q.size() != 0) && budget < 40000) begin
            if (pushed < 1000 && $urandom_range(0, 7) == 0) begin
                push_word(16'($urandom));
                pushed++;
            end
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            budget++;
        end
        if (budget >= 40000) chk("random_timeout", 32'd0, 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        chk("random_count", word_count, m_count);
        chk("random_count_abs", word_count, 32'd1004);

        // Finish with two words pending: data first, then terminator
        push_word(16'hCAFE);
        push_word(16'h5A5A);
        exp_q.push_back('{b: 8'h00, last: 1'b0});
        tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        budget = 0;
        while (!done && budget < 2000) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            budget++;
        end
        chk("finish_done", {31'd0, done}, 32'd1);
        chk("finish_drained", exp_q.size(), 32'd0);
        chk("finish_count", word_count, 32'd1006);
        src_q.push_back(16'h7777);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            chk("halted_read", {31'd0, read}, 32'd0);
            chk("halted_valid", {31'd0, byte_valid}, 32'd0);
            chk("halted_done", {31'd0, done}, 32'd1);
        end
        src_q.delete();

        // Reset while the HI byte is on the link
        tick(1'b1, 1'b1, 1'b0);
        exp_q.delete();
        push_word(16'hA55A);
        tick(1'b0, 1'b1, 1'b0);
        chk("mid_read", {31'd0, read}, 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("mid_hi", {23'd0, byte_valid, byte_out}, 32'h1A5);
        tick(1'b1, 1'b1, 1'b0);
        exp_q.delete();
        tick(1'b0, 1'b1, 1'b0);
        chk("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("mid_rst_count", word_count, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        push_word(16'h1357);
        tick(1'b0, 1'b1, 1'b0);
        chk("post_rst_read", {31'd0, read}, 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        chk("post_rst_tag", {23'd0, byte_valid, byte_out}, 32'h101);
        drain(20, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("post_rst_count", word_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
